// File: rtl/pixel_output_stage.sv
// Pixel output stage: frame-buffer word hold register, two 16-bit pixel shift registers and a registered RGB332 output mux.
// Defining PIXEL_TEST_PATTERN_EN builds the colour-bar generator; without it, outputmuxsel = 2'b11 drives black.
module pixel_output_stage #(
  parameter logic [7:0] BORDER_COLOR = 8'h49,
  parameter int         BAR_WIDTH    = 80
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pixelclk,
  input  logic        shift1load,
  input  logic        shift2load,
  input  logic        shiftmux_sel,
  input  logic [1:0]  outputmuxsel,
  input  logic        n_vsync_in,
  input  logic        n_hsync_in,
  input  logic [15:0] rdata,
  input  logic        rdata_valid,
  output logic        fetch_req,
  output logic [2:0]  red,
  output logic [2:0]  green,
  output logic [1:0]  blue,
  output logic        n_vsync,
  output logic        n_hsync,
  output logic        err_underrun,
  output logic        err_overrun
);

  logic [15:0] hold_reg;
  logic        full_reg;
  logic [15:0] shift_a_reg;
  logic [15:0] shift_b_reg;
  logic [7:0]  rgb_reg;
  logic        n_vsync_reg;
  logic        n_hsync_reg;
  logic        underrun_reg;
  logic        overrun_reg;

  logic        any_load;
  logic [15:0] load_word;
  logic [7:0]  pixel;
  logic [7:0]  pattern_color;
  logic [7:0]  rgb_next;

  assign any_load  = shift1load | shift2load;
  // An empty hold register with a word arriving this cycle forwards it straight to the shift register.
  assign load_word = full_reg ? hold_reg : (rdata_valid ? rdata : 16'h0000);
  assign pixel     = shiftmux_sel ? shift_b_reg[15:8] : shift_a_reg[15:8];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_reg     <= 16'h0000;
      full_reg     <= 1'b0;
      underrun_reg <= 1'b0;
      overrun_reg  <= 1'b0;
    end else if (any_load) begin
      if (full_reg) begin
        if (rdata_valid) hold_reg <= rdata;
        else             full_reg <= 1'b0;
      end else if (!rdata_valid) begin
        underrun_reg <= 1'b1;
      end
    end else if (rdata_valid) begin
      if (full_reg) begin
        overrun_reg <= 1'b1;
      end else begin
        hold_reg <= rdata;
        full_reg <= 1'b1;
      end
    end
  end

  // A load to the active register outranks the pixel shift.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_a_reg <= 16'h0000;
      shift_b_reg <= 16'h0000;
    end else begin
      if (shift1load)                    shift_a_reg <= load_word;
      else if (pixelclk && !shiftmux_sel) shift_a_reg <= {shift_a_reg[7:0], 8'h00};
      if (shift2load)                    shift_b_reg <= load_word;
      else if (pixelclk && shiftmux_sel)  shift_b_reg <= {shift_b_reg[7:0], 8'h00};
    end
  end

`ifdef PIXEL_TEST_PATTERN_EN
  localparam int CNT_W = (BAR_WIDTH > 1) ? $clog2(BAR_WIDTH) : 1;

  logic [CNT_W-1:0] bar_cnt_reg;
  logic [2:0]       bar_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bar_cnt_reg <= '0;
      bar_reg     <= 3'd0;
    end else if (!n_hsync_in) begin
      bar_cnt_reg <= '0;
      bar_reg     <= 3'd0;
    end else if (pixelclk && (outputmuxsel == 2'b11)) begin
      if (bar_cnt_reg == CNT_W'(BAR_WIDTH - 1)) begin
        bar_cnt_reg <= '0;
        bar_reg     <= bar_reg + 3'd1;
      end else begin
        bar_cnt_reg <= bar_cnt_reg + 1'b1;
      end
    end
  end

  assign pattern_color = {{3{bar_reg[2]}}, {3{bar_reg[1]}}, {2{bar_reg[0]}}};
`else
  assign pattern_color = 8'h00;
`endif

  always_comb begin
    rgb_next = 8'h00;
    case (outputmuxsel)
      2'b01:   rgb_next = pixel;
      2'b10:   rgb_next = BORDER_COLOR;
      2'b11:   rgb_next = pattern_color;
      default: rgb_next = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb_reg     <= 8'h00;
      n_vsync_reg <= 1'b1;
      n_hsync_reg <= 1'b1;
    end else if (pixelclk) begin
      rgb_reg     <= rgb_next;
      n_vsync_reg <= n_vsync_in;
      n_hsync_reg <= n_hsync_in;
    end
  end

  assign fetch_req    = !full_reg;
  assign red          = rgb_reg[7:5];
  assign green        = rgb_reg[4:2];
  assign blue         = rgb_reg[1:0];
  assign n_vsync      = n_vsync_reg;
  assign n_hsync      = n_hsync_reg;
  assign err_underrun = underrun_reg;
  assign err_overrun  = overrun_reg;

endmodule

// File: tb/tb_pixel_output_stage.sv
// Directed testbench for pixel_output_stage; honours PIXEL_TEST_PATTERN_EN for the colour-bar expectations.
`timescale 1ns/1ps
module tb_pixel_output_stage;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pixelclk = 1'b0;
  logic        shift1load = 1'b0;
  logic        shift2load = 1'b0;
  logic        shiftmux_sel = 1'b0;
  logic [1:0]  outputmuxsel = 2'b00;
  logic        n_vsync_in = 1'b1;
  logic        n_hsync_in = 1'b1;
  logic [15:0] rdata = 16'h0000;
  logic        rdata_valid = 1'b0;
  logic        fetch_req;
  logic [2:0]  red;
  logic [2:0]  green;
  logic [1:0]  blue;
  logic        n_vsync;
  logic        n_hsync;
  logic        err_underrun;
  logic        err_overrun;

  int errors = 0;
  int checks = 0;
  logic [7:0] rgb;
  assign rgb = {red, green, blue};

  pixel_output_stage dut (
    .clk(clk), .rst(rst), .pixelclk(pixelclk), .shift1load(shift1load),
    .shift2load(shift2load), .shiftmux_sel(shiftmux_sel), .outputmuxsel(outputmuxsel),
    .n_vsync_in(n_vsync_in), .n_hsync_in(n_hsync_in), .rdata(rdata),
    .rdata_valid(rdata_valid), .fetch_req(fetch_req), .red(red), .green(green),
    .blue(blue), .n_vsync(n_vsync), .n_hsync(n_hsync),
    .err_underrun(err_underrun), .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe();
    pixelclk = 1'b1;
    tick();
    pixelclk = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    shift1load = 0; shift2load = 0; rdata_valid = 0; pixelclk = 0;
    shiftmux_sel = 0; outputmuxsel = 2'b00; n_vsync_in = 1; n_hsync_in = 1;
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (rgb !== 8'h00)       begin errors++; $display("FAIL reset_rgb got %h want 00", rgb); end
    checks++; if (n_vsync !== 1'b1)    begin errors++; $display("FAIL reset_vsync got %b want 1", n_vsync); end
    checks++; if (n_hsync !== 1'b1)    begin errors++; $display("FAIL reset_hsync got %b want 1", n_hsync); end
    checks++; if (fetch_req !== 1'b1)  begin errors++; $display("FAIL reset_fetch got %b want 1", fetch_req); end
    checks++; if (err_underrun !== 0)  begin errors++; $display("FAIL reset_underrun got %b want 0", err_underrun); end
    checks++; if (err_overrun !== 0)   begin errors++; $display("FAIL reset_overrun got %b want 0", err_overrun); end
    $display("test_reset done");
  endtask

  task automatic test_pixel_path();
    do_reset();
    rdata = 16'hE01C; rdata_valid = 1; tick(); rdata_valid = 0;
    checks++; if (fetch_req !== 1'b0) begin errors++; $display("FAIL pix_full got %b want 0", fetch_req); end
    shift1load = 1; tick(); shift1load = 0;
    checks++; if (fetch_req !== 1'b1) begin errors++; $display("FAIL pix_empty got %b want 1", fetch_req); end
    outputmuxsel = 2'b01;
    tick();
    checks++; if (rgb !== 8'h00) begin errors++; $display("FAIL pix_no_strobe got %h want 00", rgb); end
    strobe();
    checks++; if (rgb !== 8'hE0) begin errors++; $display("FAIL pix_first got %h want E0", rgb); end
    tick(); tick();
    checks++; if (rgb !== 8'hE0) begin errors++; $display("FAIL pix_hold got %h want E0", rgb); end
    strobe();
    checks++; if (rgb !== 8'h1C) begin errors++; $display("FAIL pix_second got %h want 1C", rgb); end
    strobe();
    checks++; if (rgb !== 8'h00) begin errors++; $display("FAIL pix_third got %h want 00", rgb); end
    checks++; if ({err_underrun, err_overrun} !== 2'b00) begin errors++; $display("FAIL pix_flags got %b want 00", {err_underrun, err_overrun}); end
    $display("test_pixel_path done");
  endtask

  task automatic test_underrun();
    do_reset();
    outputmuxsel = 2'b01; shiftmux_sel = 1;
    shift2load = 1; rdata = 16'hFFFF; rdata_valid = 1; tick(); shift2load = 0; rdata_valid = 0;
    checks++; if (err_underrun !== 1'b0) begin errors++; $display("FAIL bypass_underrun got %b want 0", err_underrun); end
    checks++; if (fetch_req !== 1'b1)    begin errors++; $display("FAIL bypass_fetch got %b want 1", fetch_req); end
    strobe();
    checks++; if (rgb !== 8'hFF) begin errors++; $display("FAIL bypass_hi got %h want FF", rgb); end
    strobe();
    checks++; if (rgb !== 8'hFF) begin errors++; $display("FAIL bypass_lo got %h want FF", rgb); end
    rdata = 16'hABCD;
    shift2load = 1; tick(); shift2load = 0;
    checks++; if (err_underrun !== 1'b1) begin errors++; $display("FAIL underrun_flag got %b want 1", err_underrun); end
    strobe();
    checks++; if (rgb !== 8'h00) begin errors++; $display("FAIL underrun_zero got %h want 00", rgb); end
    tick(); tick();
    checks++; if (err_underrun !== 1'b1) begin errors++; $display("FAIL underrun_sticky got %b want 1", err_underrun); end
    $display("test_underrun done");
  endtask

  task automatic test_overrun();
    do_reset();
    rdata = 16'h1111; rdata_valid = 1; tick();
    rdata = 16'h2222; tick(); rdata_valid = 0;
    checks++; if (err_overrun !== 1'b1) begin errors++; $display("FAIL overrun_flag got %b want 1", err_overrun); end
    checks++; if (fetch_req !== 1'b0)   begin errors++; $display("FAIL overrun_fetch got %b want 0", fetch_req); end
    shift1load = 1; tick(); shift1load = 0;
    outputmuxsel = 2'b01; strobe();
    checks++; if (rgb !== 8'h11) begin errors++; $display("FAIL overrun_kept got %h want 11", rgb); end
    checks++; if (err_underrun !== 1'b0) begin errors++; $display("FAIL overrun_underrun got %b want 0", err_underrun); end
    $display("test_overrun done");
  endtask

  task automatic test_back_to_back();
    do_reset();
    outputmuxsel = 2'b01;
    rdata = 16'hAABB; rdata_valid = 1; tick();
    rdata = 16'hCCDD; shift1load = 1; tick(); shift1load = 0; rdata_valid = 0;
    checks++; if (fetch_req !== 1'b0)   begin errors++; $display("FAIL b2b_full got %b want 0", fetch_req); end
    checks++; if (err_overrun !== 1'b0) begin errors++; $display("FAIL b2b_overrun got %b want 0", err_overrun); end
    strobe();
    checks++; if (rgb !== 8'hAA) begin errors++; $display("FAIL b2b_a got %h want AA", rgb); end
    shift2load = 1; tick(); shift2load = 0;
    shiftmux_sel = 1; strobe();
    checks++; if (rgb !== 8'hCC) begin errors++; $display("FAIL b2b_b got %h want CC", rgb); end
    // Dual load, then a load racing a shift on the active register.
    shiftmux_sel = 0;
    rdata = 16'h1234; rdata_valid = 1; tick(); rdata_valid = 0;
    shift1load = 1; shift2load = 1; tick(); shift1load = 0; shift2load = 0;
    checks++; if (fetch_req !== 1'b1) begin errors++; $display("FAIL dual_fetch got %b want 1", fetch_req); end
    strobe();
    checks++; if (rgb !== 8'h12) begin errors++; $display("FAIL dual_a got %h want 12", rgb); end
    shiftmux_sel = 1; strobe();
    checks++; if (rgb !== 8'h12) begin errors++; $display("FAIL dual_b got %h want 12", rgb); end
    shiftmux_sel = 0;
    rdata = 16'h5678; rdata_valid = 1; tick(); rdata_valid = 0;
    shift1load = 1; strobe(); shift1load = 0;
    checks++; if (rgb !== 8'h34) begin errors++; $display("FAIL prio_old got %h want 34", rgb); end
    strobe();
    checks++; if (rgb !== 8'h56) begin errors++; $display("FAIL prio_load got %h want 56", rgb); end
    $display("test_back_to_back done");
  endtask

  task automatic test_border_sync();
    do_reset();
    outputmuxsel = 2'b10; tick();
    checks++; if (rgb !== 8'h00) begin errors++; $display("FAIL border_wait got %h want 00", rgb); end
    strobe();
    checks++; if (rgb !== 8'h49) begin errors++; $display("FAIL border got %h want 49", rgb); end
    outputmuxsel = 2'b00; strobe();
    checks++; if (rgb !== 8'h00) begin errors++; $display("FAIL black got %h want 00", rgb); end
    n_hsync_in = 0; tick();
    checks++; if (n_hsync !== 1'b1) begin errors++; $display("FAIL hsync_hold got %b want 1", n_hsync); end
    strobe();
    checks++; if (n_hsync !== 1'b0) begin errors++; $display("FAIL hsync got %b want 0", n_hsync); end
    checks++; if (n_vsync !== 1'b1) begin errors++; $display("FAIL vsync_idle got %b want 1", n_vsync); end
    n_vsync_in = 0; n_hsync_in = 1; strobe();
    checks++; if (n_vsync !== 1'b0) begin errors++; $display("FAIL vsync got %b want 0", n_vsync); end
    checks++; if (n_hsync !== 1'b1) begin errors++; $display("FAIL hsync_rel got %b want 1", n_hsync); end
    $display("test_border_sync done");
  endtask

  task automatic test_pattern();
    logic [7:0] exp;
    int bad = 0;
    do_reset();
    n_hsync_in = 0; tick(); n_hsync_in = 1;
    outputmuxsel = 2'b11;
    for (int i = 0; i < 161; i++) begin
      strobe();
`ifdef PIXEL_TEST_PATTERN_EN
      exp = (i < 80) ? 8'h00 : ((i < 160) ? 8'h03 : 8'h1C);
`else
      exp = 8'h00;
`endif
      checks++;
      if (rgb !== exp) begin
        errors++; bad++;
        if (bad < 5) $display("FAIL pattern_px%0d got %h want %h", i, rgb, exp);
      end
    end
    n_hsync_in = 0; tick(); n_hsync_in = 1;
    strobe();
    checks++; if (rgb !== 8'h00) begin errors++; $display("FAIL pattern_restart got %h want 00", rgb); end
    $display("test_pattern done");
  endtask

  task automatic test_reset_midline();
    do_reset();
    rdata = 16'h9999; rdata_valid = 1; tick(); rdata_valid = 0;
    shift1load = 1; tick(); shift1load = 0;
    rdata = 16'h7777; rdata_valid = 1; tick(); rdata_valid = 0;
    outputmuxsel = 2'b01; strobe();
    checks++; if (rgb !== 8'h99) begin errors++; $display("FAIL mid_pre got %h want 99", rgb); end
    #2 rst = 1'b1;
    #1;
    checks++; if (fetch_req !== 1'b1) begin errors++; $display("FAIL mid_async_fetch got %b want 1", fetch_req); end
    checks++; if (rgb !== 8'h00)      begin errors++; $display("FAIL mid_async_rgb got %h want 00", rgb); end
    tick(); rst = 1'b0; tick();
    strobe();
    checks++; if (rgb !== 8'h00) begin errors++; $display("FAIL mid_residue got %h want 00", rgb); end
    shift1load = 1; tick(); shift1load = 0;
    checks++; if (err_underrun !== 1'b1) begin errors++; $display("FAIL mid_hold_cleared got %b want 1", err_underrun); end
    $display("test_reset_midline done");
  endtask

  initial begin
    test_reset();
    test_pixel_path();
    test_underrun();
    test_overrun();
    test_back_to_back();
    test_border_sync();
    test_pattern();
    test_reset_midline();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
